// File: rtl/dmem_pkg.sv
// Shared definitions for the memory-stage access sequencer: funct3 size
// codes, FSM state encoding, default timeout and a funct3 legality helper.
package dmem_pkg;

    // RV32I load/store funct3 size and sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Default number of REQ cycles allowed before a bus error is declared
    localparam int unsigned TIMEOUT_CYC_DEF = 32'd255;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The unsigned sizes only exist for loads; stores accept B/H/W only
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_load);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = is_load;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory port bundle: request side driven by the sequencer (master),
// acknowledge/read-data side driven by the memory (slave).
interface dmem_access_ctrl_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_ack,
        output dmem_rdata
    );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter: derives byte enables, lane-replicated store data,
// the misalignment flag and the extended load result from the low address
// bits and funct3. Purely combinational.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  f3_i,
    input  logic [31:0] sdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o,
    output logic        misalign_o
);

    logic [31:0] shifted_s;

    // Bring the addressed lane down to bit 0 of the read word
    always_comb begin
        shifted_s = rdata_i >> {off_i, 3'b000};
    end

    // Store-side lane placement and alignment check by access size
    always_comb begin
        be_o       = 4'b0000;
        wdata_o    = 32'h0000_0000;
        misalign_o = 1'b0;
        case (f3_i)
            F3_B, F3_BU: begin
                be_o       = 4'b0001 << off_i;
                wdata_o    = {4{sdata_i[7:0]}};
                misalign_o = 1'b0;
            end
            F3_H, F3_HU: begin
                be_o       = 4'b0011 << {off_i[1], 1'b0};
                wdata_o    = {2{sdata_i[15:0]}};
                misalign_o = off_i[0];
            end
            F3_W: begin
                be_o       = 4'b1111;
                wdata_o    = sdata_i;
                misalign_o = |off_i;
            end
            default: begin
                be_o       = 4'b0000;
                wdata_o    = 32'h0000_0000;
                misalign_o = 1'b0;
            end
        endcase
    end

    // Sign or zero extension of the selected load lane
    always_comb begin
        ld_data_o = 32'h0000_0000;
        case (f3_i)
            F3_B:    ld_data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    ld_data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    ld_data_o = rdata_i;
            F3_BU:   ld_data_o = {24'h00_0000, shifted_s[7:0]};
            F3_HU:   ld_data_o = {16'h0000, shifted_s[15:0]};
            default: ld_data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage access sequencer. Runs the EX/MEM load/store against a
// req/ack data-memory port, stalls the pipeline while the access is in
// flight, returns formatted load data and reports misaligned, illegal and
// timed-out accesses as one-cycle pulses in DONE.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYC = dmem_pkg::TIMEOUT_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                me_alu_o,
    input  logic [31:0]                me_regs_data2,
    input  logic                       me_mem_read,
    input  logic                       me_mem_write,
    input  logic [2:0]                 me_func3_code,
    output logic                       pipe_stall,
    output logic [31:0]                ld_data,
    output logic                       ld_valid,
    output logic                       misalign_err,
    output logic                       bus_err,
    dmem_access_ctrl_if.master         dmem
);

    import dmem_pkg::*;

    // Counter value seen in the last REQ cycle that is still allowed to wait
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 32'd1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        ld_valid_q, ld_valid_d;
    logic        mis_q, mis_d;
    logic        bus_q, bus_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        is_load_q, is_load_d;

    logic        access_s;
    logic        legal_s;
    logic [1:0]  fmt_off_s;
    logic [2:0]  fmt_f3_s;
    logic [3:0]  fmt_be_s;
    logic [31:0] fmt_wdata_s;
    logic [31:0] fmt_ld_s;
    logic        fmt_mis_s;

    // Decode whether an access is present and whether its type is legal
    always_comb begin
        access_s = me_mem_read | me_mem_write;
        legal_s  = (me_mem_read ^ me_mem_write) & f3_legal(me_func3_code, me_mem_read);
    end

    // While waiting, format against the captured access rather than the live inputs
    always_comb begin
        if (state_q == ST_REQ) begin
            fmt_off_s = off_q;
            fmt_f3_s  = f3_q;
        end else begin
            fmt_off_s = me_alu_o[1:0];
            fmt_f3_s  = me_func3_code;
        end
    end

    dmem_lane_fmt u_lane_fmt (
        .off_i      (fmt_off_s),
        .f3_i       (fmt_f3_s),
        .sdata_i    (me_regs_data2),
        .rdata_i    (dmem.dmem_rdata),
        .be_o       (fmt_be_s),
        .wdata_o    (fmt_wdata_s),
        .ld_data_o  (fmt_ld_s),
        .misalign_o (fmt_mis_s)
    );

    // Next-state and next-register logic for the IDLE/REQ/DONE sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        ld_data_d  = ld_data_q;
        ld_valid_d = 1'b0;
        mis_d      = 1'b0;
        bus_d      = 1'b0;
        f3_d       = f3_q;
        off_d      = off_q;
        is_load_d  = is_load_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (access_s) begin
                    if (!legal_s) begin
                        state_d   = ST_DONE;
                        bus_d     = 1'b1;
                        ld_data_d = 32'h0000_0000;
                    end else if (fmt_mis_s) begin
                        state_d   = ST_DONE;
                        mis_d     = 1'b1;
                        ld_data_d = 32'h0000_0000;
                    end else begin
                        state_d   = ST_REQ;
                        req_d     = 1'b1;
                        we_d      = me_mem_write;
                        addr_d    = {me_alu_o[31:2], 2'b00};
                        wdata_d   = me_mem_write ? fmt_wdata_s : 32'h0000_0000;
                        be_d      = fmt_be_s;
                        f3_d      = me_func3_code;
                        off_d     = me_alu_o[1:0];
                        is_load_d = me_mem_read;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem.dmem_ack) begin
                    state_d    = ST_DONE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    cnt_d      = 8'd0;
                    ld_valid_d = is_load_q;
                    ld_data_d  = is_load_q ? fmt_ld_s : 32'h0000_0000;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ST_DONE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    cnt_d     = 8'd0;
                    bus_d     = 1'b1;
                    ld_data_d = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Timeout counter, bus-side registers and result pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            be_q       <= 4'b0000;
            ld_data_q  <= 32'h0000_0000;
            ld_valid_q <= 1'b0;
            mis_q      <= 1'b0;
            bus_q      <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            is_load_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
            mis_q      <= mis_d;
            bus_q      <= bus_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            is_load_q  <= is_load_d;
        end
    end

    // Stall while an access is detected or outstanding; released in DONE so
    // the instruction advances once. Gated by reset so it drops immediately.
    always_comb begin
        pipe_stall = rst & (((state_q == ST_IDLE) & access_s) | (state_q == ST_REQ));
    end

    assign ld_data         = ld_data_q;
    assign ld_valid        = ld_valid_q;
    assign misalign_err    = mis_q;
    assign bus_err         = bus_q;
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: a table of directed vectors with hand-derived
// expectations, hand sequences for timeout/late-ack and reset mid-request,
// then random back-to-back accesses against a size/offset arithmetic model.
module tb_dmem_access_ctrl;

    localparam int TO = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        int          ack_after;
    } txn_t;

    typedef struct packed {
        int          stall;
        int          reqc;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic        ld_valid;
        logic        mis;
        logic        bus;
        logic        chk_ld;
    } exp_t;

    typedef struct packed {
        txn_t t;
        exp_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] me_alu_o;
    logic [31:0] me_regs_data2;
    logic        me_mem_read;
    logic        me_mem_write;
    logic [2:0]  me_func3_code;
    logic        pipe_stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        misalign_err;
    logic        bus_err;

    int n_run  = 0;
    int n_fail = 0;

    dmem_access_ctrl_if dmem_if ();

    dmem_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .me_alu_o      (me_alu_o),
        .me_regs_data2 (me_regs_data2),
        .me_mem_read   (me_mem_read),
        .me_mem_write  (me_mem_write),
        .me_func3_code (me_func3_code),
        .pipe_stall    (pipe_stall),
        .ld_data       (ld_data),
        .ld_valid      (ld_valid),
        .misalign_err  (misalign_err),
        .bus_err       (bus_err),
        .dmem          (dmem_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic txn_t mk_t(input logic [31:0] addr, input logic [31:0] data,
                                  input logic [31:0] rdata, input logic rd, input logic wr,
                                  input logic [2:0] f3, input int ack_after);
        txn_t t;
        t.addr = addr; t.data = data; t.rdata = rdata; t.rd = rd; t.wr = wr;
        t.f3 = f3; t.ack_after = ack_after;
        return t;
    endfunction

    function automatic exp_t mk_e(input int stall, input int reqc, input logic we,
                                  input logic [3:0] be, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] ld,
                                  input logic ldv, input logic mis, input logic bus,
                                  input logic chk_ld);
        exp_t e;
        e.stall = stall; e.reqc = reqc; e.we = we; e.be = be; e.addr = addr;
        e.wdata = wdata; e.ld = ld; e.ld_valid = ldv; e.mis = mis; e.bus = bus;
        e.chk_ld = chk_ld;
        return e;
    endfunction

    // Reference: access size in bytes, alignment by modulo, lanes by arithmetic
    function automatic exp_t model(input txn_t t);
        exp_t        e;
        int          f3i, size, off, reqc;
        bit          legal, timeout;
        longint      v, mask;
        logic [31:0] w;
        f3i   = int'(t.f3);
        legal = (t.rd != t.wr) && ((f3i <= 2) || (t.rd && (f3i == 4 || f3i == 5)));
        size  = (f3i % 4 == 0) ? 1 : ((f3i % 4 == 1) ? 2 : 4);
        off   = int'(t.addr % 4);
        e = mk_e(1, 0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (!legal) begin
            e.bus = 1'b1;
        end else if ((t.addr % size) != 0) begin
            e.mis = 1'b1;
        end else begin
            timeout = !(t.ack_after >= 1 && t.ack_after <= TO);
            reqc    = timeout ? TO : t.ack_after;
            e.stall = 1 + reqc;
            e.reqc  = reqc;
            e.we    = t.wr;
            e.be    = 4'(((1 << size) - 1) << off);
            e.addr  = t.addr - 32'(off);
            w = 32'h0;
            for (int i = 0; i < 4; i++)
                w = w | (((t.data >> (8 * (i % size))) & 32'hFF) << (8 * i));
            e.wdata = w;
            mask = (longint'(1) << (8 * size)) - 1;
            v    = (longint'(t.rdata) >> (8 * off)) & mask;
            if (f3i < 4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
            e.bus      = timeout;
            e.ld_valid = t.rd && !timeout;
            e.ld       = timeout ? 32'h0 : 32'(v);
            e.chk_ld   = t.rd || timeout;
        end
        return e;
    endfunction

    // Present one access in IDLE, act as memory with the given ack latency,
    // and check bus fields every REQ cycle plus the DONE-cycle results
    task automatic run_txn(input txn_t t, input exp_t e, input string tag);
        int stall_n;
        int req_n;
        bit done;
        @(negedge clk);
        me_alu_o = t.addr; me_regs_data2 = t.data; me_mem_read = t.rd;
        me_mem_write = t.wr; me_func3_code = t.f3;
        dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = t.rdata;
        #1;
        chk({tag, ":idle_quiet"}, 32'({ld_valid, misalign_err, bus_err, dmem_if.dmem_req}), 32'h0);
        stall_n = 0; req_n = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            if (pipe_stall) begin
                stall_n++;
                if (dmem_if.dmem_req) begin
                    req_n++;
                    chk({tag, ":addr"}, dmem_if.dmem_addr, e.addr);
                    chk({tag, ":we"}, 32'(dmem_if.dmem_we), 32'(e.we));
                    chk({tag, ":be"}, 32'(dmem_if.dmem_be), 32'(e.be));
                    if (e.we) chk({tag, ":wdata"}, dmem_if.dmem_wdata, e.wdata);
                    dmem_if.dmem_ack = (req_n == t.ack_after);
                end else begin
                    dmem_if.dmem_ack = 1'b0;
                end
            end else begin
                done = 1'b1;
                dmem_if.dmem_ack = 1'b0;
                chk({tag, ":stall_cycles"}, 32'(stall_n), 32'(e.stall));
                chk({tag, ":req_cycles"}, 32'(req_n), 32'(e.reqc));
                chk({tag, ":done_req_we"}, 32'({dmem_if.dmem_req, dmem_if.dmem_we}), 32'h0);
                chk({tag, ":ld_valid"}, 32'(ld_valid), 32'(e.ld_valid));
                chk({tag, ":misalign_err"}, 32'(misalign_err), 32'(e.mis));
                chk({tag, ":bus_err"}, 32'(bus_err), 32'(e.bus));
                if (e.chk_ld) chk({tag, ":ld_data"}, ld_data, e.ld);
            end
        end
        if (!done) chk({tag, ":no_done_within_bound"}, 32'(done), 32'h1);
    endtask

    vec_t vecs[14];
    txn_t rt;

    initial begin
        rst = 1'b0;
        me_alu_o = 32'h0; me_regs_data2 = 32'h0; me_mem_read = 1'b0;
        me_mem_write = 1'b0; me_func3_code = 3'b000;
        dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = 32'h0;

        // Directed vectors with hand-computed expectations
        vecs[0].t  = mk_t(32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 3'b010, 3);
        vecs[0].e  = mk_e(4, 3, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[1].t  = mk_t(32'h103, 32'h0, 32'h80112233, 1'b1, 1'b0, 3'b000, 1);
        vecs[1].e  = mk_e(2, 1, 1'b0, 4'b1000, 32'h100, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[2].t  = mk_t(32'h103, 32'h0, 32'h80112233, 1'b1, 1'b0, 3'b100, 1);
        vecs[2].e  = mk_e(2, 1, 1'b0, 4'b1000, 32'h100, 32'h0, 32'h00000080, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[3].t  = mk_t(32'h102, 32'h0000ABCD, 32'h0, 1'b0, 1'b1, 3'b001, 2);
        vecs[3].e  = mk_e(3, 2, 1'b1, 4'b1100, 32'h100, 32'hABCDABCD, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[4].t  = mk_t(32'h101, 32'h11223344, 32'h0, 1'b0, 1'b1, 3'b010, 1);
        vecs[4].e  = mk_e(1, 0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[5].t  = mk_t(32'h101, 32'h0, 32'h12345678, 1'b1, 1'b0, 3'b001, 1);
        vecs[5].e  = mk_e(1, 0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[6].t  = mk_t(32'h100, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0, 3'b010, 0);
        vecs[6].e  = mk_e(5, 4, 1'b0, 4'hF, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[7].t  = mk_t(32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 3'b011, 1);
        vecs[7].e  = mk_e(1, 0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[8].t  = mk_t(32'h100, 32'h0, 32'h0, 1'b1, 1'b1, 3'b010, 1);
        vecs[8].e  = mk_e(1, 0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[9].t  = mk_t(32'h101, 32'h12345678, 32'h0, 1'b0, 1'b1, 3'b000, 1);
        vecs[9].e  = mk_e(2, 1, 1'b1, 4'b0010, 32'h100, 32'h78787878, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[10].t = mk_t(32'h102, 32'h0, 32'hBEEF1234, 1'b1, 1'b0, 3'b101, 1);
        vecs[10].e = mk_e(2, 1, 1'b0, 4'b1100, 32'h100, 32'h0, 32'h0000BEEF, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[11].t = mk_t(32'h102, 32'h0, 32'hBEEF1234, 1'b1, 1'b0, 3'b001, 1);
        vecs[11].e = mk_e(2, 1, 1'b0, 4'b1100, 32'h100, 32'h0, 32'hFFFFBEEF, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[12].t = mk_t(32'h100, 32'h55, 32'h0, 1'b0, 1'b1, 3'b100, 1);
        vecs[12].e = mk_e(1, 0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[13].t = mk_t(32'h104, 32'h0, 32'h01234567, 1'b1, 1'b0, 3'b010, 4);
        vecs[13].e = mk_e(5, 4, 1'b0, 4'hF, 32'h104, 32'h0, 32'h01234567, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset state
        #12;
        chk("rst_stall", 32'(pipe_stall), 32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_pulses", 32'({ld_valid, misalign_err, bus_err}), 32'h0);
        chk("rst_req_we_be", 32'({dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_be}), 32'h0);
        chk("rst_addr", dmem_if.dmem_addr, 32'h0);
        chk("rst_wdata", dmem_if.dmem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++)
            run_txn(vecs[i].t, vecs[i].e, $sformatf("vec%0d", i));

        // Timeout, then an ack arriving outside REQ must be ignored
        run_txn(vecs[6].t, vecs[6].e, "to_late");
        @(negedge clk);
        me_mem_read = 1'b0; me_mem_write = 1'b0;
        dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("late_ack_req", 32'({dmem_if.dmem_req, pipe_stall}), 32'h0);
        @(negedge clk);
        #1;
        chk("late_ack_quiet", 32'({ld_valid, bus_err, dmem_if.dmem_req, pipe_stall}), 32'h0);
        chk("late_ack_ld_data", ld_data, 32'h0);
        dmem_if.dmem_ack = 1'b0;

        // Reset asserted while a request is outstanding
        @(negedge clk);
        me_alu_o = 32'h200; me_mem_read = 1'b1; me_mem_write = 1'b0; me_func3_code = 3'b010;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midrst_req_before", 32'(dmem_if.dmem_req), 32'h1);
        rst = 1'b0;
        #1;
        chk("midrst_req_stall", 32'({dmem_if.dmem_req, pipe_stall}), 32'h0);
        chk("midrst_pulses", 32'({ld_valid, bus_err, misalign_err, dmem_if.dmem_we}), 32'h0);
        me_mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_after_release", 32'({dmem_if.dmem_req, pipe_stall, ld_valid}), 32'h0);
        rt = mk_t(32'h204, 32'h0, 32'h0BADF00D, 1'b1, 1'b0, 3'b010, 2);
        run_txn(rt, model(rt), "post_rst_lw");

        // Random back-to-back accesses with occasional idle gaps
        for (int k = 0; k < 150; k++) begin
            int kind;
            kind  = int'($urandom_range(0, 9));
            rt.rd = (kind < 6) || (kind == 9);
            rt.wr = (kind >= 6);
            if ($urandom_range(0, 7) == 0) rt.f3 = 3'($urandom_range(0, 7));
            else if (rt.rd && !rt.wr && $urandom_range(0, 1) == 1) rt.f3 = 3'($urandom_range(4, 5));
            else rt.f3 = 3'($urandom_range(0, 2));
            rt.addr = $urandom;
            if ($urandom_range(0, 1) == 1) rt.addr[0] = 1'b0;
            if ($urandom_range(0, 1) == 1) rt.addr[1] = 1'b0;
            rt.data  = $urandom;
            rt.rdata = $urandom;
            rt.ack_after = int'($urandom_range(0, 5));
            run_txn(rt, model(rt), $sformatf("rnd%0d", k));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                me_mem_read = 1'b0; me_mem_write = 1'b0;
            end
        end

        @(negedge clk);
        me_mem_read = 1'b0; me_mem_write = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage data-memory access sequencer for the 5-stage core. It takes the load/store held in the EX/MEM pipeline register and runs it against a data-memory port that may take several cycles to respond, using a req/ack handshake. While the access is outstanding it stalls the pipeline, and it returns sign- or zero-extended load data to the write-back path. It also detects misaligned, illegal and timed-out accesses and reports them as one-cycle error pulses.

## Interface
- TIMEOUT_CYC, 255: maximum REQ cycles waiting for ack before a bus error is declared; legal range 1–255.
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- me_alu_o  in  32  effective byte address.
- me_regs_data2  in  32  store data, taken from the low lanes.
- me_mem_read  in  1  the ME-stage instruction is a load.
- me_mem_write  in  1  the ME-stage instruction is a store.
- me_func3_code  in  3  access size and sign (RV32I funct3).
- pipe_stall  out  1  holds the IF through MEM pipeline registers.
- ld_data  out  32  formatted load result; valid in DONE.
- ld_valid  out  1  one-cycle pulse; ld_data is valid.
- misalign_err  out  1  one-cycle pulse in DONE.
- bus_err  out  1  one-cycle pulse in DONE, for a timeout or an illegal access.
- dmem_req  out  1  request; held until ack.
- dmem_we  out  1  1 for a store.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  access complete; dmem_rdata is valid in the same cycle.
- dmem_rdata  in  32  read word.

## Operation
- The FSM has three states: IDLE, REQ and DONE. The reset state is IDLE.
- An access is present when me_mem_read or me_mem_write is set.
- IDLE with an access present:
  - If the access is legal and aligned, the block registers addr, we, wdata and be, and moves to REQ.
  - Otherwise it moves to DONE with the matching error flag set and issues no bus request.
- REQ:
  - dmem_req=1 and the timeout counter increments.
  - On dmem_ack the block captures the formatted rdata (loads only) and moves to DONE.
  - When the counter reaches TIMEOUT_CYC without ack, the block drops the request, sets bus_err and moves to DONE. ld_data is 0 in this case.
- DONE: emits ld_valid (loads, no error) or the error pulse, then moves to IDLE unconditionally. The counter clears.
- pipe_stall = (IDLE && access) || REQ. It is deasserted in DONE, so the instruction advances exactly once.
- Sizes:
  - funct3 000 = byte, 001 = half, 010 = word.
  - For loads, 100 = byte unsigned and 101 = half unsigned.
  - Any other funct3 is illegal and raises bus_err.
  - Read and write asserted together is also illegal and raises bus_err.
- Alignment: a half needs addr[0]=0; a word needs addr[1:0]=00.
- Byte enables: byte gives 4'b0001<<addr[1:0]; half gives 4'b0011<<{addr[1],1'b0}; word gives 4'hF.
- Store data: byte → {4{d[7:0]}}, half → {2{d[15:0]}}, word → d.
- Load data: the selected lane is shifted down by the address offset, then sign-extended (000, 001) or zero-extended (100, 101).
- A store that errors never drives dmem_we or dmem_req.

## Timing
- All outputs except pipe_stall are registered. pipe_stall is combinational from the state and the access inputs.
- Reset values: state IDLE; pipe_stall=0 (no access present); ld_data=0; ld_valid=0; misalign_err=0; bus_err=0; dmem_req=0; dmem_we=0; dmem_addr=0; dmem_wdata=0; dmem_be=0; counter 0.
- Latency with ack in the first REQ cycle: stall for 2 cycles, DONE in the 3rd. Each extra wait cycle adds one stall cycle.
- Error path: 1 stall cycle, then DONE.
- dmem_addr, dmem_we, dmem_wdata and dmem_be are stable for the whole time dmem_req is high.
- After dmem_req rises, it falls only on the cycle following ack or timeout.
- An ack seen outside REQ is ignored.
- Back-to-back accesses: the sequence DONE → IDLE → REQ gives one bubble-free detect cycle in IDLE.
- Reset asserted mid-REQ: all outputs drop asynchronously, the request is abandoned and no result is produced.

## Structure
- Package dmem_pkg holds:
  - the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum;
  - the default value of TIMEOUT_CYC.
- Sub-module dmem_lane_fmt is purely combinational. It takes addr[1:0], funct3, store data and rdata, and produces be, wdata, ld_data and misalign. The controller holds the FSM, the counter and the registers.

## Test plan
- LW with addr 0x100 and ack after 3 REQ cycles with rdata 0xDEADBEEF: pipe_stall is high for 4 cycles, ld_data=0xDEADBEEF, ld_valid pulses once.
- LB at 0x103 with rdata 0x80112233: be=4'b1000 and ld_data=0xFFFFFF80. LBU with the same inputs gives 0x00000080.
- SH at 0x102 with data 0x0000ABCD: dmem_we=1, be=4'b1100, wdata=0xABCDABCD, and the stall ends the cycle after ack.
- SW at 0x101: no dmem_req, misalign_err pulses, 1 stall cycle. LH at 0x101 behaves the same.
- LW with no ack, TIMEOUT_CYC=4: dmem_req is high for 4 cycles, then bus_err pulses with ld_data=0. A late ack after that is ignored.
- rst driven low during REQ: dmem_req and pipe_stall drop within the reset assertion. After release the state is IDLE and a new LW completes normally.
